// File: rtl/mc_pkg.sv
// Shared types and opcode constants for the multi-cycle instruction sequencer.
package mc_pkg;

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EXE  = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_HALT = 3'd5,
    ST_TRAP = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    CL_ALU,
    CL_BRANCH,
    CL_LOAD,
    CL_STORE,
    CL_JUMP,
    CL_LINK,
    CL_HALT,
    CL_ILLEGAL
  } opclass_e;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_ORI  = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_OR   = 6'b010010;
  localparam logic [5:0] OP_SLL  = 6'b011000;
  localparam logic [5:0] OP_SLTI = 6'b011100;
  localparam logic [5:0] OP_SW   = 6'b100110;
  localparam logic [5:0] OP_LW   = 6'b100111;
  localparam logic [5:0] OP_BEQ  = 6'b110000;
  localparam logic [5:0] OP_BNE  = 6'b110001;
  localparam logic [5:0] OP_BLTZ = 6'b110010;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_JR   = 6'b111001;
  localparam logic [5:0] OP_JAL  = 6'b111010;
  localparam logic [5:0] OP_HALT = 6'b111111;

endpackage

// File: rtl/mc_opclass.sv
// Combinational opcode classifier; anything not in the opcode table is ILLEGAL.
module mc_opclass
  import mc_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic [OPW-1:0] op,
  output opclass_e       op_class
);

  always_comb begin
    op_class = CL_ILLEGAL;
    case (op)
      OPW'(OP_ADD), OPW'(OP_SUB), OPW'(OP_ADDI), OPW'(OP_ORI),
      OPW'(OP_AND), OPW'(OP_OR), OPW'(OP_SLL), OPW'(OP_SLTI): op_class = CL_ALU;
      OPW'(OP_BEQ), OPW'(OP_BNE), OPW'(OP_BLTZ):               op_class = CL_BRANCH;
      OPW'(OP_LW):                                              op_class = CL_LOAD;
      OPW'(OP_SW):                                              op_class = CL_STORE;
      OPW'(OP_J), OPW'(OP_JR):                                  op_class = CL_JUMP;
      OPW'(OP_JAL):                                             op_class = CL_LINK;
      OPW'(OP_HALT):                                            op_class = CL_HALT;
      default:                                                  op_class = CL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle instruction sequencer: walks IF/ID/EXE/MEM/WB per instruction class
// and issues IR/PC/register/data-memory strobes plus memory requests.
//
// state | meaning
// IF    | fetch; imem_req held until the phase completes, IRWre on completion
// ID    | decode op into a class and latch it; jumps finish here
// EXE   | execute; branches finish here
// MEM   | data access; dmem_req held until completion; stores finish here
// WB    | register write-back, PC update
// HALT  | halt opcode seen; absorbing until Reset
// TRAP  | illegal opcode seen; absorbing until Reset
module mc_sequencer
  import mc_pkg::*;
#(
  parameter int OPW       = 6,
  parameter int CNT_W     = 32,
  parameter int WAIT_MODE = 1
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [OPW-1:0]   op,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  input  logic             stall,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             IRWre,
  output logic             PCWre,
  output logic             RegWre,
  output logic             DataMemRW,
  output logic [2:0]       phase,
  output logic             halted,
  output logic             trap,
  output logic [CNT_W-1:0] retired
);

  state_e           state_q, state_d;
  opclass_e         cls_q, cls_d;
  opclass_e         cls_dec;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             halted_q, halted_d;
  logic             trap_q, trap_d;
  logic             imem_done, dmem_done;

  mc_opclass #(.OPW(OPW)) u_opclass (
    .op       (op),
    .op_class (cls_dec)
  );

  // Zero-wait memories complete every cycle regardless of the ack lines.
  assign imem_done = (WAIT_MODE == 0) || imem_ack;
  assign dmem_done = (WAIT_MODE == 0) || dmem_ack;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_IF;
      cls_q     <= CL_ALU;
      retired_q <= '0;
      halted_q  <= 1'b0;
      trap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      retired_q <= retired_d;
      halted_q  <= halted_d;
      trap_q    <= trap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    if (!stall) begin
      case (state_q)
        ST_IF: if (imem_done) state_d = ST_ID;
        ST_ID: begin
          cls_d = cls_dec;
          case (cls_dec)
            CL_ALU, CL_BRANCH, CL_LOAD, CL_STORE: state_d = ST_EXE;
            CL_JUMP, CL_LINK:                     state_d = ST_IF;
            CL_HALT:                              state_d = ST_HALT;
            default:                              state_d = ST_TRAP;
          endcase
        end
        ST_EXE: begin
          case (cls_q)
            CL_BRANCH:          state_d = ST_IF;
            CL_LOAD, CL_STORE:  state_d = ST_MEM;
            default:            state_d = ST_WB;
          endcase
        end
        ST_MEM: if (dmem_done) state_d = (cls_q == CL_STORE) ? ST_IF : ST_WB;
        ST_WB:  state_d = ST_IF;
        default: state_d = state_q;
      endcase
    end
    halted_d  = (state_d == ST_HALT);
    trap_d    = (state_d == ST_TRAP);
    retired_d = retired_q + CNT_W'(PCWre);
  end

  always_comb begin
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    IRWre     = 1'b0;
    PCWre     = 1'b0;
    RegWre    = 1'b0;
    DataMemRW = 1'b0;
    if (!Reset) begin
      case (state_q)
        ST_IF: begin
          imem_req = 1'b1;
          IRWre    = !stall && imem_done;
        end
        ST_ID: begin
          PCWre  = !stall && (cls_dec == CL_JUMP || cls_dec == CL_LINK);
          RegWre = !stall && (cls_dec == CL_LINK);
        end
        ST_EXE: PCWre = !stall && (cls_q == CL_BRANCH);
        ST_MEM: begin
          dmem_req  = 1'b1;
          DataMemRW = !stall && (cls_q == CL_STORE);
          PCWre     = !stall && dmem_done && (cls_q == CL_STORE);
        end
        ST_WB: begin
          RegWre = !stall;
          PCWre  = !stall;
        end
        default: ;
      endcase
    end
  end

  assign phase   = state_q;
  assign halted  = halted_q;
  assign trap    = trap_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Bench for mc_sequencer: zero-wait, handshake and 4-bit-counter instances share
// one stimulus stream and are checked every cycle against a route-based model.
module tb_mc_sequencer;

  localparam int P_IF = 0, P_ID = 1, P_EXE = 2, P_MEM = 3, P_WB = 4, P_HALT = 5, P_TRAP = 6;
  localparam int K_ALU = 0, K_BR = 1, K_LD = 2, K_ST = 3, K_J = 4, K_LINK = 5, K_HALT = 6, K_ILL = 7;

  localparam logic [5:0] O_ADD = 6'b000000, O_SUB = 6'b000001, O_ADDI = 6'b000010;
  localparam logic [5:0] O_ORI = 6'b010000, O_AND = 6'b010001, O_OR = 6'b010010;
  localparam logic [5:0] O_SLL = 6'b011000, O_SLTI = 6'b011100, O_SW = 6'b100110;
  localparam logic [5:0] O_LW = 6'b100111, O_BEQ = 6'b110000, O_BNE = 6'b110001;
  localparam logic [5:0] O_BLTZ = 6'b110010, O_J = 6'b111000, O_JR = 6'b111001;
  localparam logic [5:0] O_JAL = 6'b111010, O_HALT = 6'b111111, O_ILL = 6'b101010;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic [5:0]  op = O_ADD;
  logic        imem_ack = 1'b1, dmem_ack = 1'b1, stall = 1'b0;

  // strobe vectors: {imem_req, dmem_req, IRWre, PCWre, RegWre, DataMemRW}
  logic [5:0]  s0, s1, s2;
  logic [2:0]  ph0, ph1, ph2;
  logic        hl0, hl1, hl2, tr0, tr1, tr2;
  logic [31:0] ret0, ret1;
  logic [3:0]  ret2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  mc_sequencer #(.OPW(6), .CNT_W(32), .WAIT_MODE(0)) u_d0 (
    .CLK(CLK), .Reset(Reset), .op(op), .imem_ack(imem_ack), .dmem_ack(dmem_ack), .stall(stall),
    .imem_req(s0[5]), .dmem_req(s0[4]), .IRWre(s0[3]), .PCWre(s0[2]), .RegWre(s0[1]),
    .DataMemRW(s0[0]), .phase(ph0), .halted(hl0), .trap(tr0), .retired(ret0));

  mc_sequencer #(.OPW(6), .CNT_W(32), .WAIT_MODE(1)) u_d1 (
    .CLK(CLK), .Reset(Reset), .op(op), .imem_ack(imem_ack), .dmem_ack(dmem_ack), .stall(stall),
    .imem_req(s1[5]), .dmem_req(s1[4]), .IRWre(s1[3]), .PCWre(s1[2]), .RegWre(s1[1]),
    .DataMemRW(s1[0]), .phase(ph1), .halted(hl1), .trap(tr1), .retired(ret1));

  mc_sequencer #(.OPW(6), .CNT_W(4), .WAIT_MODE(0)) u_d2 (
    .CLK(CLK), .Reset(Reset), .op(op), .imem_ack(imem_ack), .dmem_ack(dmem_ack), .stall(stall),
    .imem_req(s2[5]), .dmem_req(s2[4]), .IRWre(s2[3]), .PCWre(s2[2]), .RegWre(s2[1]),
    .DataMemRW(s2[0]), .phase(ph2), .halted(hl2), .trap(tr2), .retired(ret2));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: each instruction is IF, ID, then a class-specific list of remaining phases.
  int          mph [2];
  int          mkind [2];
  int          rt [2][3];
  int          rlen [2];
  int          ridx [2];
  logic [31:0] mret [2];

  function automatic int kind_of(input logic [5:0] o);
    case (o)
      O_ADD, O_SUB, O_ADDI, O_ORI, O_AND, O_OR, O_SLL, O_SLTI: return K_ALU;
      O_BEQ, O_BNE, O_BLTZ: return K_BR;
      O_LW:   return K_LD;
      O_SW:   return K_ST;
      O_J, O_JR: return K_J;
      O_JAL:  return K_LINK;
      O_HALT: return K_HALT;
      default: return K_ILL;
    endcase
  endfunction

  task automatic model_eval(input int m, output logic [5:0] es);
    bit done;
    int k;
    es = '0;
    if (Reset) begin
      mph[m] = P_IF; mret[m] = 0; rlen[m] = 0; ridx[m] = 0; mkind[m] = K_ALU;
      return;
    end
    done = 0;
    case (mph[m])
      P_IF:  begin es[5] = 1'b1; done = (m == 0) || imem_ack; end
      P_MEM: begin
        es[4] = 1'b1;
        done  = (m == 0) || dmem_ack;
        es[0] = !stall && (mkind[m] == K_ST);
      end
      P_ID, P_EXE, P_WB: done = 1;
      default: done = 0;
    endcase
    if (stall || !done) return;
    if (mph[m] == P_IF) begin
      es[3] = 1'b1; mph[m] = P_ID;
      return;
    end
    if (mph[m] == P_ID) begin
      k = kind_of(op); mkind[m] = k; ridx[m] = 0; rlen[m] = 0;
      case (k)
        K_ALU: begin rt[m][0] = P_EXE; rt[m][1] = P_WB; rlen[m] = 2; end
        K_BR:  begin rt[m][0] = P_EXE; rlen[m] = 1; end
        K_LD:  begin rt[m][0] = P_EXE; rt[m][1] = P_MEM; rt[m][2] = P_WB; rlen[m] = 3; end
        K_ST:  begin rt[m][0] = P_EXE; rt[m][1] = P_MEM; rlen[m] = 2; end
        K_HALT: begin mph[m] = P_HALT; return; end
        K_ILL:  begin mph[m] = P_TRAP; return; end
        default: rlen[m] = 0;
      endcase
    end
    if (ridx[m] < rlen[m]) begin
      mph[m] = rt[m][ridx[m]];
      ridx[m]++;
    end else begin
      es[2] = 1'b1;
      es[1] = (mph[m] == P_WB) || (mph[m] == P_ID && mkind[m] == K_LINK);
      mret[m] = mret[m] + 1;
      mph[m] = P_IF;
    end
  endtask

  always @(negedge CLK) begin
    logic [5:0]  es0, es1;
    int          p0, p1;
    logic [31:0] r0, r1;
    p0 = Reset ? P_IF : mph[0];
    p1 = Reset ? P_IF : mph[1];
    r0 = Reset ? 32'd0 : mret[0];
    r1 = Reset ? 32'd0 : mret[1];
    model_eval(0, es0);
    model_eval(1, es1);
    check("strobes_d0", s0, es0);
    check("phase_d0", ph0, p0);
    check("halted_d0", hl0, p0 == P_HALT);
    check("trap_d0", tr0, p0 == P_TRAP);
    check("retired_d0", ret0, r0);
    check("strobes_d1", s1, es1);
    check("phase_d1", ph1, p1);
    check("halted_d1", hl1, p1 == P_HALT);
    check("trap_d1", tr1, p1 == P_TRAP);
    check("retired_d1", ret1, r1);
    check("strobes_d2", s2, es0);
    check("phase_d2", ph2, p0);
    check("retired_d2", ret2, r0[3:0]);
  end

  task automatic do_reset();
    Reset = 1'b1;
    @(posedge CLK); #1;
    Reset = 1'b0;
  endtask

  // Runs one instruction on the zero-wait path and returns how many cycles it took.
  task automatic run_instr(input logic [5:0] o, output int n);
    op = o;
    n = 0;
    do begin
      @(posedge CLK); #1;
      n++;
    end while (mph[0] != P_IF && n < 12);
    check("instr_done", mph[0] == P_IF, 1);
  endtask

  initial begin
    int n;
    int irw_cnt, irw_cyc, any_strobe;
    logic [31:0] r9;
    logic [5:0] prog [5];
    int         plen [5];
    logic [5:0] mix [11];
    int         mlen [11];
    int         sph [10];
    prog = '{O_ADD, O_LW, O_SW, O_BEQ, O_J};
    plen = '{4, 5, 4, 3, 2};
    mix  = '{O_SUB, O_ADDI, O_ORI, O_AND, O_OR, O_SLL, O_SLTI, O_BNE, O_BLTZ, O_JR, O_JAL};
    mlen = '{4, 4, 4, 4, 4, 4, 4, 3, 3, 2, 2};
    sph  = '{P_IF, P_ID, P_EXE, P_MEM, P_MEM, P_MEM, P_MEM, P_MEM, P_MEM, P_IF};

    repeat (2) @(posedge CLK);
    #1;
    check("rst_phase", ph0, 0);
    check("rst_retired", ret0, 0);
    check("rst_imem_req", s0[5], 0);
    Reset = 1'b0;
    #1;
    check("post_rst_imem_req", s0[5], 1);

    // zero-wait program: add, lw, sw, beq, j
    for (int i = 0; i < 5; i++) begin
      run_instr(prog[i], n);
      check("prog_len", n, plen[i]);
    end
    check("prog_retired_d0", ret0, 5);
    check("prog_retired_model", mret[0], 5);
    check("prog_retired_d1", ret1, 5);

    for (int i = 0; i < 11; i++) begin
      run_instr(mix[i], n);
      check("mix_len", n, mlen[i]);
    end
    check("mix_retired_d0", ret0, 16);
    check("mix_retired_d2_wrap", ret2, 0);

    // handshake lw: imem_ack on cycle 4, dmem_ack on cycle 9
    do_reset();
    op = O_LW;
    irw_cnt = 0; irw_cyc = 0; r9 = 32'hFFFF_FFFF;
    for (int c = 1; c <= 10; c++) begin
      imem_ack = (c == 4);
      dmem_ack = (c == 9);
      @(negedge CLK); #1;
      if (s1[3]) begin irw_cnt++; irw_cyc = c; end
      if (c == 9) r9 = ret1;
      if (c == 10) check("lw_wb_phase_d1", ph1, P_WB);
      @(posedge CLK); #1;
    end
    check("lw_irw_count", irw_cnt, 1);
    check("lw_irw_cycle", irw_cyc, 4);
    check("lw_ret_c9", r9, 0);
    check("lw_retired_d1", ret1, 1);

    // stall of sw in MEM with a discarded ack on the second stall cycle
    imem_ack = 1'b1; dmem_ack = 1'b0;
    do_reset();
    op = O_SW;
    for (int c = 1; c <= 10; c++) begin
      stall    = (c >= 4 && c <= 7);
      dmem_ack = (c == 5) || (c == 9);
      @(negedge CLK); #1;
      check("stall_phase_d1", ph1, sph[c-1]);
      if (c == 5) begin
        check("stall_dmem_req", s1[4], 1);
        check("stall_datamemrw", s1[0], 0);
        check("stall_pcwre", s1[2], 0);
      end
      if (c == 9) begin
        check("sw_done_pcwre", s1[2], 1);
        check("sw_done_datamemrw", s1[0], 1);
      end
      @(posedge CLK); #1;
    end
    stall = 1'b0; dmem_ack = 1'b1;
    check("sw_retired_d1", ret1, 1);

    // illegal opcode traps and stays silent
    do_reset();
    op = O_ILL;
    any_strobe = 0;
    for (int c = 1; c <= 22; c++) begin
      @(negedge CLK); #1;
      if (c >= 3 && (s0 != 0 || s1 != 0)) any_strobe++;
      @(posedge CLK); #1;
    end
    check("trap_d0", tr0, 1);
    check("trap_d1", tr1, 1);
    check("trap_phase", ph0, P_TRAP);
    check("trap_quiet", any_strobe, 0);
    check("trap_retired", ret0, 0);
    do_reset();
    check("trap_cleared", tr0, 0);
    check("trap_cleared_phase", ph0, P_IF);

    op = O_HALT;
    repeat (6) begin @(posedge CLK); #1; end
    check("halt_halted", hl0, 1);
    check("halt_phase", ph1, P_HALT);
    check("halt_retired", ret0, 0);

    // 17 jumps wrap the 4-bit counter
    do_reset();
    op = O_J;
    repeat (34) begin @(posedge CLK); #1; end
    check("jumps_d2_wrap", ret2, 1);
    check("jumps_d0", ret0, 17);

    // reset asserted mid-WB of a load
    do_reset();
    op = O_J;
    repeat (2) begin @(posedge CLK); #1; end
    op = O_LW;
    repeat (4) begin @(posedge CLK); #1; end
    @(negedge CLK); #1;
    check("wb_phase_before", ph0, P_WB);
    check("wb_regwre_before", s0[1], 1);
    check("wb_retired_before", ret0, 1);
    Reset = 1'b1;
    #1;
    check("wb_regwre_reset", s0[1], 0);
    check("wb_retired_reset", ret0, 0);
    check("wb_phase_reset", ph0, P_IF);
    check("wb_strobes_d1_reset", s1, 0);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    Reset = 1'b0;
    #1;
    check("restart_imem_req", s0[5], 1);
    check("restart_phase", ph0, P_IF);
    repeat (3) begin @(posedge CLK); #1; end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

endmodule
